// File: rtl/count_event_monitor.sv
// count_event_monitor: classifies counter changes, queues WRAP/JUMP events.
// Optional COUNT_MON_HOLD_CHECK_EN: a held counter emits a STALL event.
module count_event_monitor #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count0,
    input  logic [WIDTH-1:0] count1,
    input  logic [WIDTH-1:0] count2,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH+3:0] evt_data,
    output logic             overflow,
    output logic [7:0]       err_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] cnt [3];
    logic [WIDTH-1:0] prev [3];
    logic [WIDTH-1:0] delta [3];
    logic [WIDTH-1:0] pend_d [3];
    logic [1:0]       pend_k [3];
    logic [1:0]       kind [3];
    logic [2:0]       primed, pend_v;
    logic [2:0]       wrap, hold, jump, fire, load, drain;
    logic             drop;

    logic [WIDTH+3:0] mem [DEPTH];
    logic [AW-1:0]    rptr, wptr;
    logic [AW:0]      used;
    logic             full, pop, push;
    logic [1:0]       win;
    logic [1:0]       njump;
    logic [8:0]       esum;
    logic [7:0]       err_next;

    assign cnt[0] = count0;
    assign cnt[1] = count1;
    assign cnt[2] = count2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            delta[i] = cnt[i] - prev[i];
            wrap[i]  = (&prev[i]) && (cnt[i] == '0);
            hold[i]  = (delta[i] == '0);
            jump[i]  = en && primed[i] && !wrap[i] && !hold[i]
                       && (delta[i] != WIDTH'(1));
`ifdef COUNT_MON_HOLD_CHECK_EN
            fire[i]  = en && primed[i] && (wrap[i] || hold[i]) || jump[i];
            kind[i]  = wrap[i] ? 2'd1 : (hold[i] ? 2'd3 : 2'd2);
`else
            fire[i]  = en && primed[i] && wrap[i] || jump[i];
            kind[i]  = wrap[i] ? 2'd1 : 2'd2;
`endif
        end
    end

    // Fixed-priority arbiter: ch0 > ch1 > ch2, one slot per cycle.
    always_comb begin
        if (pend_v[0])      win = 2'd0;
        else if (pend_v[1]) win = 2'd1;
        else                win = 2'd2;
    end

    assign full      = (used == (AW+1)'(DEPTH));
    assign evt_valid = (used != '0);
    assign evt_data  = mem[rptr];
    assign pop       = evt_valid && evt_ready;
    assign push      = (|pend_v) && (!full || pop);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            drain[i] = push && (win == 2'(i));
            load[i]  = fire[i] && (!pend_v[i] || drain[i]);
        end
        drop = |(fire & ~load);
    end

    assign njump    = 2'(jump[0]) + 2'(jump[1]) + 2'(jump[2]);
    assign esum     = {1'b0, err_cnt} + 9'(njump);
    assign err_next = esum[8] ? 8'hFF : esum[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev     <= '{default: '0};
            pend_d   <= '{default: '0};
            pend_k   <= '{default: '0};
            primed   <= '0;
            pend_v   <= '0;
            overflow <= 1'b0;
            err_cnt  <= '0;
            rptr     <= '0;
            wptr     <= '0;
            used     <= '0;
            for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (en) begin
                    prev[i]   <= cnt[i];
                    primed[i] <= 1'b1;
                end
                if (load[i]) begin
                    pend_v[i] <= 1'b1;
                    pend_k[i] <= kind[i];
                    pend_d[i] <= cnt[i];
                end else if (drain[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end
            if (drop) overflow <= 1'b1;
            err_cnt <= err_next;
            if (push) begin
                mem[wptr] <= {win, pend_k[win], pend_d[win]};
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            used <= used + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_count_event_monitor.sv
// tb_count_event_monitor: directed and random stimulus against a
// queue-based reference model of the event monitor.
module tb_count_event_monitor;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        evt_ready = 1'b0;
    logic [7:0]  count0 = '0, count1 = '0, count2 = '0;
    logic        evt_valid, overflow;
    logic [11:0] evt_data;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    count_event_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .en(en),
        .count0(count0), .count1(count1), .count2(count2),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_data(evt_data), .overflow(overflow), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int          m_prev [3];
    bit          m_primed [3];
    bit          m_pv [3];
    logic [11:0] m_pe [3];
    logic [11:0] m_fifo [$];
    bit          m_ovf;
    int          m_err;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 0; m_primed[i] = 0; m_pv[i] = 0; m_pe[i] = '0;
        end
        m_fifo.delete();
        m_ovf = 0;
        m_err = 0;
    endtask

    task automatic model_step();
        int c [3];
        int win, d, kind;
        bit pop, push, ev;
        c = '{int'(count0), int'(count1), int'(count2)};
        pop = (m_fifo.size() > 0) && evt_ready;
        win = -1;
        for (int i = 0; i < 3; i++) if (m_pv[i] && win < 0) win = i;
        push = (win >= 0) && (m_fifo.size() < DEPTH || pop);
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            m_fifo.push_back(m_pe[win]);
            m_pv[win] = 0;
        end
        if (en) begin
            for (int i = 0; i < 3; i++) begin
                if (!m_primed[i]) begin
                    m_primed[i] = 1;
                end else begin
                    ev = 0; kind = 0;
                    d = (c[i] - m_prev[i] + 256) % 256;
                    if (m_prev[i] == 255 && c[i] == 0) begin
                        ev = 1; kind = 1;
                    end else if (d == 0) begin
`ifdef COUNT_MON_HOLD_CHECK_EN
                        ev = 1; kind = 3;
`endif
                    end else if (d != 1) begin
                        ev = 1; kind = 2;
                        if (m_err < 255) m_err++;
                    end
                    if (ev) begin
                        if (!m_pv[i]) begin
                            m_pv[i] = 1;
                            m_pe[i] = 12'(i * 1024 + kind * 256 + c[i]);
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
                m_prev[i] = c[i];
            end
        end
    endtask

    task automatic compare();
        check("evt_valid", evt_valid, m_fifo.size() > 0);
        if (m_fifo.size() > 0) check("evt_data", evt_data, m_fifo[0]);
        check("overflow", overflow, m_ovf);
        check("err_cnt", err_cnt, m_err);
    endtask

    task automatic cyc(input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic e,
                       input logic r);
        count0 = c0; count1 = c1; count2 = c2;
        en = e; evt_ready = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic mid_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rst_valid", evt_valid, 0);
        check("rst_data", evt_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_err", err_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] v [3];
        model_reset();
        #1;
        check("reset_valid", evt_valid, 0);
        check("reset_data", evt_data, 0);
        check("reset_ovf", overflow, 0);
        check("reset_err", err_cnt, 0);
        @(negedge clk);
        reset = 1'b1;

        // Wrap on ch0.
        cyc(8'hFD, 8'h10, 8'h80, 1, 1);
        cyc(8'hFE, 8'h10, 8'h80, 1, 1);
        cyc(8'hFF, 8'h10, 8'h80, 1, 1);
        cyc(8'h00, 8'h10, 8'h80, 1, 1);
`ifndef COUNT_MON_HOLD_CHECK_EN
        check("wrap_lat", evt_valid, 0);
        cyc(8'h00, 8'h10, 8'h80, 1, 1);
        check("wrap_valid", evt_valid, 1);
        check("wrap_data", evt_data, 12'h100);
        cyc(8'h00, 8'h10, 8'h80, 1, 1);
        check("wrap_once", evt_valid, 0);
`endif
        check("wrap_err", err_cnt, 0);

        // Jump on ch1, then saturate err_cnt.
        cyc(8'h00, 8'h20, 8'h80, 1, 1);
        check("jump_err", err_cnt, 1);
`ifndef COUNT_MON_HOLD_CHECK_EN
        cyc(8'h00, 8'h20, 8'h80, 1, 1);
        check("jump_data", evt_data, 12'h620);
`endif
        for (int i = 0; i < 300; i++)
            cyc(8'h00, (i % 2 == 0) ? 8'h10 : 8'h20, 8'h80, 1, 1);
        check("err_sat", err_cnt, 255);
        check("b2b_ovf", overflow, 0);
        cyc(8'h00, 8'h20, 8'h80, 1, 1);
        cyc(8'h00, 8'h20, 8'h80, 1, 1);

        // All channels jump together.
        cyc(8'h50, 8'h60, 8'h70, 1, 1);
        for (int k = 0; k < 3; k++) begin
            cyc(8'h50, 8'h60, 8'h70, 1, 1);
`ifndef COUNT_MON_HOLD_CHECK_EN
            check("simul_ch", 32'(evt_data[11:10]), k);
`endif
        end
        check("simul_ovf", overflow, 0);

        // Backpressure until an event is dropped, then drain.
        cyc(8'h10, 8'h60, 8'h70, 1, 0);
        cyc(8'h30, 8'h60, 8'h70, 1, 0);
        cyc(8'h50, 8'h60, 8'h70, 1, 0);
        cyc(8'h70, 8'h60, 8'h70, 1, 0);
        cyc(8'h90, 8'h60, 8'h70, 1, 0);
        cyc(8'hB0, 8'h60, 8'h70, 1, 0);
        cyc(8'hB0, 8'h60, 8'h70, 0, 0);
        check("bp_ovf", overflow, 1);
        check("bp_full", evt_valid, 1);
        for (int k = 0; k < 6; k++) cyc(8'hB0, 8'h60, 8'h70, 0, 1);
        check("bp_empty", evt_valid, 0);

        // Reset with events queued, then priming and enable gating.
        cyc(8'h20, 8'h60, 8'h70, 1, 0);
        cyc(8'h40, 8'h60, 8'h70, 1, 0);
        cyc(8'h40, 8'h60, 8'h70, 0, 0);
        cyc(8'h40, 8'h60, 8'h70, 0, 0);
        check("pre_rst_valid", evt_valid, 1);
        mid_reset();
        cyc(8'h33, 8'h44, 8'h55, 1, 1);
        cyc(8'h33, 8'h44, 8'h55, 0, 1);
        check("prime_only", evt_valid, 0);
        cyc(8'h33, 8'h44, 8'h99, 0, 1);
        cyc(8'h33, 8'h44, 8'h99, 0, 1);
        cyc(8'h33, 8'h44, 8'h55, 0, 1);
        check("en_gate", evt_valid, 0);
        check("en_err", err_cnt, 0);

        // Hold on ch0.
        cyc(8'h05, 8'h44, 8'h55, 1, 1);
        cyc(8'h05, 8'h44, 8'h55, 1, 1);
        cyc(8'h05, 8'h44, 8'h55, 1, 1);
        cyc(8'h05, 8'h44, 8'h55, 1, 1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            v = '{count0, count1, count2};
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: v[i] = v[i] + 8'd1;
                    5, 6:          v[i] = v[i];
                    7:             v[i] = 8'hFF;
                    default:       v[i] = 8'($urandom);
                endcase
            end
            if (n == 300) mid_reset();
            cyc(v[0], v[1], v[2], $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
